// File: rtl/cic_uart_pkg.sv
// Shared types and constants for the CIC sample UART transmitter.
package cic_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   FRAME_BITS = 10;
    localparam int   BYTE_BITS  = 8;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cic_uart_tx_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    import cic_uart_pkg::*;

    localparam int PTR_W = cnt_width(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == LVL_W'(0));
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage write; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/cic_uart_tx.sv
// Captures CIC decimated words on rising edges of the decimation clock,
// queues them, and sends each one as an 8N1 UART frame.
module cic_uart_tx #(
    parameter int DATA_WIDTH   = 7,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sample_clk_in,
    input  logic [DATA_WIDTH-1:0]           sample_in,
    output logic                            uart_tx,
    output logic                            busy,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    import cic_uart_pkg::*;

    localparam int                BAUD_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t                state_r;
    logic                     sclk_q_r;
    logic [BAUD_W-1:0]        baud_r;
    logic [2:0]               bit_cnt_r;
    logic [BYTE_BITS-1:0]     shift_r;
    logic                     tx_r;
    logic                     busy_r;
    logic                     overflow_r;
    logic                     push_s;
    logic                     pop_s;
    logic                     baud_last_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [DATA_WIDTH-1:0]    fifo_rdata_s;
    logic [BYTE_BITS-1:0]     byte_s;

    assign push_s      = sample_clk_in & ~sclk_q_r;
    assign baud_last_s = (baud_r == BAUD_LAST);
    assign byte_s      = BYTE_BITS'(fifo_rdata_s);
    assign uart_tx     = tx_r;
    assign busy        = busy_r;
    assign overflow    = overflow_r;

    // Pop when idle with data waiting, or on the last stop cycle to chain frames.
    always_comb begin
        pop_s = 1'b0;
        if (state_r == IDLE) begin
            pop_s = ~fifo_empty_s;
        end else if (state_r == STOP) begin
            pop_s = baud_last_s & ~fifo_empty_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (sample_in),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Delay the decimation clock by one cycle for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q_r <= 1'b0;
        end else begin
            sclk_q_r <= sample_clk_in;
        end
    end

    // Sticky drop flag: a push into a full FIFO with no pop loses the sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (push_s & fifo_full_s & ~pop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Transmit FSM with baud/bit counters, shift register and registered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            baud_r    <= BAUD_W'(0);
            bit_cnt_r <= 3'd0;
            shift_r   <= {BYTE_BITS{1'b0}};
            tx_r      <= STOP_BIT;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_r    <= BAUD_W'(0);
                    bit_cnt_r <= 3'd0;
                    if (!fifo_empty_s) begin
                        shift_r <= byte_s;
                        state_r <= START;
                        tx_r    <= START_BIT;
                        busy_r  <= 1'b1;
                    end else begin
                        tx_r    <= STOP_BIT;
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last_s) begin
                        baud_r    <= BAUD_W'(0);
                        bit_cnt_r <= 3'd0;
                        state_r   <= DATA;
                        tx_r      <= shift_r[0];
                    end else begin
                        baud_r    <= baud_r + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_last_s) begin
                        baud_r    <= BAUD_W'(0);
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        shift_r   <= shift_r >> 1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= STOP;
                            tx_r    <= STOP_BIT;
                        end else begin
                            tx_r    <= shift_r[1];
                        end
                    end else begin
                        baud_r    <= baud_r + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_last_s) begin
                        baud_r <= BAUD_W'(0);
                        if (!fifo_empty_s) begin
                            shift_r <= byte_s;
                            state_r <= START;
                            tx_r    <= START_BIT;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= STOP_BIT;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    baud_r  <= BAUD_W'(0);
                    tx_r    <= STOP_BIT;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cic_uart_tx.sv
// Directed bench for cic_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_cic_uart_tx;

    localparam int DW  = 7;
    localparam int CPB = 4;
    localparam int FD  = 4;
    localparam int LW  = $clog2(FD + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_clk_in = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          uart_tx;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    int n_cmp = 0;
    int n_err = 0;
    logic stream_q[$];

    cic_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_clk_in (sample_clk_in),
        .sample_in     (sample_in),
        .uart_tx       (uart_tx),
        .busy          (busy),
        .overflow      (overflow),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_clk_in = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // One rising edge of the decimation clock carrying value v (2 cycles).
    task automatic pulse(input logic [DW-1:0] v);
        sample_in = v;
        sample_clk_in = 1'b1;
        tick();
        sample_clk_in = 1'b0;
        tick();
    endtask

    // Expected line levels for one 8N1 frame, CPB samples per bit.
    task automatic add_frame(input logic [7:0] b);
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < CPB; c++) begin
                if (k == 0)      stream_q.push_back(1'b0);
                else if (k == 9) stream_q.push_back(1'b1);
                else             stream_q.push_back(b[k-1]);
            end
        end
    endtask

    // Compare the line every cycle against the queued expectation.
    task automatic expect_stream();
        int n;
        n = stream_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("tx_line[%0d]", i), {31'd0, uart_tx}, {31'd0, stream_q[i]});
            tick();
        end
        stream_q.delete();
    endtask

    initial begin
        logic line_and;

        // Reset values and a quiet line.
        do_reset();
        check_eq("rst_tx", {31'd0, uart_tx}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        line_and = 1'b1;
        repeat (20) begin
            tick();
            line_and = line_and & uart_tx;
        end
        check_eq("idle_line_high", {31'd0, line_and}, 32'd1);

        // Single frame 0x55 with 2-cycle push-to-start latency.
        sample_in = 7'h55;
        sample_clk_in = 1'b1;
        tick();
        check_eq("sf_level_push", 32'(fifo_level), 32'd1);
        check_eq("sf_tx_before", {31'd0, uart_tx}, 32'd1);
        check_eq("sf_busy_before", {31'd0, busy}, 32'd0);
        sample_clk_in = 1'b0;
        tick();
        check_eq("sf_busy", {31'd0, busy}, 32'd1);
        check_eq("sf_level_pop", 32'(fifo_level), 32'd0);
        add_frame(8'h55);
        expect_stream();
        check_eq("sf_busy_after", {31'd0, busy}, 32'd0);
        check_eq("sf_tx_after", {31'd0, uart_tx}, 32'd1);

        // Back-to-back frames with no idle gap.
        pulse(7'h01);
        add_frame(8'h01);
        add_frame(8'h7F);
        add_frame(8'h40);
        fork
            expect_stream();
            begin
                sample_in = 7'h7F;
                sample_clk_in = 1'b1;
                tick();
                check_eq("b2b_level1", 32'(fifo_level), 32'd1);
                sample_clk_in = 1'b0;
                tick();
                sample_in = 7'h40;
                sample_clk_in = 1'b1;
                tick();
                check_eq("b2b_level2", 32'(fifo_level), 32'd2);
                sample_clk_in = 1'b0;
            end
        join
        check_eq("b2b_level_end", 32'(fifo_level), 32'd0);
        check_eq("b2b_busy_end", {31'd0, busy}, 32'd0);

        // Overflow: six edges during the first frame, the sixth is dropped.
        do_reset();
        pulse(7'h11);
        add_frame(8'h11);
        add_frame(8'h22);
        add_frame(8'h33);
        add_frame(8'h44);
        add_frame(8'h55);
        fork
            expect_stream();
            begin
                pulse(7'h22);
                pulse(7'h33);
                pulse(7'h44);
                pulse(7'h55);
                check_eq("ovf_before", {31'd0, overflow}, 32'd0);
                check_eq("ovf_full_level", 32'(fifo_level), 32'd4);
                pulse(7'h66);
                check_eq("ovf_set", {31'd0, overflow}, 32'd1);
                check_eq("ovf_level_held", 32'(fifo_level), 32'd4);
            end
        join
        check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
        check_eq("ovf_busy_end", {31'd0, busy}, 32'd0);
        check_eq("ovf_level_end", 32'(fifo_level), 32'd0);

        // Full FIFO with a push exactly on the last stop cycle: no drop.
        do_reset();
        pulse(7'h0A);
        add_frame(8'h0A);
        add_frame(8'h0B);
        add_frame(8'h0C);
        add_frame(8'h0D);
        add_frame(8'h0E);
        add_frame(8'h0F);
        fork
            expect_stream();
            begin
                pulse(7'h0B);
                pulse(7'h0C);
                pulse(7'h0D);
                pulse(7'h0E);
                check_eq("fsp_full", 32'(fifo_level), 32'd4);
                repeat (31) tick();
                sample_in = 7'h0F;
                sample_clk_in = 1'b1;
                tick();
                sample_clk_in = 1'b0;
                check_eq("fsp_level", 32'(fifo_level), 32'd4);
                check_eq("fsp_no_ovf", {31'd0, overflow}, 32'd0);
            end
        join
        check_eq("fsp_ovf_end", {31'd0, overflow}, 32'd0);
        check_eq("fsp_level_end", 32'(fifo_level), 32'd0);

        // Reset during data bit 3 of a frame with another sample queued.
        pulse(7'h2A);
        pulse(7'h15);
        check_eq("mr_level_pre", 32'(fifo_level), 32'd1);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        check_eq("mr_tx", {31'd0, uart_tx}, 32'd1);
        check_eq("mr_busy", {31'd0, busy}, 32'd0);
        check_eq("mr_level", 32'(fifo_level), 32'd0);
        tick();
        rst = 1'b0;
        line_and = 1'b1;
        repeat (60) begin
            tick();
            line_and = line_and & uart_tx & ~busy;
        end
        check_eq("mr_no_residual", {31'd0, line_and}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cic_uart_tx.md
# cic_uart_tx

Downstream consumer of the CIC decimator output in the micro-tile CIC design. It samples each 7-bit decimated CIC word on the rising edge of the CIC's decimation clock and queues it in a small FIFO. Each queued word is serialized as an 8N1 UART frame on a single output pin. This lets the filtered PDM result be read by any host UART without a parallel bus.

## Interface
Parameters:
- `DATA_WIDTH`, 7: width of the CIC output word.
- `CLKS_PER_BIT`, 16: `clk` cycles per UART bit. Legal range is 1 or more.
- `FIFO_DEPTH`, 4: number of sample entries. Must be a power of two, 2 or more.

Ports:
- `clk`, input, 1: single system clock, same as the CIC's. All logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `sample_clk_in`, input, 1: CIC decimation clock level, treated as a plain data signal.
- `sample_in`, input, `DATA_WIDTH`: CIC decimated output word.
- `uart_tx`, output, 1: serial line. Idle level is high.
- `busy`, output, 1: high while a frame is on the line.
- `overflow`, output, 1: sticky flag, set when a sample is dropped.
- `fifo_level`, output, `$clog2(FIFO_DEPTH+1)`: current FIFO occupancy.

## Operation
- **Edge detect**
  - Register `sample_clk_in` into `sclk_q`.
  - `push` = `sample_clk_in & ~sclk_q`.
  - On a cycle with `push`, `sample_in` is captured as-is.
- **Byte format**
  - Byte = `{(8-DATA_WIDTH)'b0, sample_in}`.
- **FIFO**
  - Synchronous, first-in first-out.
  - Push when full and no pop in the same cycle: the sample is dropped and `overflow` is set to 1. It stays 1 until `rst`.
  - Push and pop in the same cycle when full: both happen and nothing is dropped.
  - Push and pop in the same cycle when empty: not possible, because a pop requires a non-empty FIFO.
- **TX state machine** (states IDLE, START, DATA, STOP)
  - IDLE: `uart_tx`=1. If the FIFO is not empty, pop into the shift register and go to START.
  - START: `uart_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, `CLKS_PER_BIT` cycles each. A 3-bit bit counter wraps 7→0 and then moves to STOP.
  - STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles.
    - If the FIFO is not empty on the last STOP cycle, pop and go directly to START, with no idle bit.
    - Otherwise go to IDLE.
- **Outputs**
  - `busy` = state is not IDLE.
  - `uart_tx` is driven from a register with no combinational glitches.
  - Baud counter counts 0..`CLKS_PER_BIT`-1 and wraps. It resets to 0 on every state entry.
- **Reset** (also when asserted mid-frame)
  - `uart_tx`=1, `busy`=0, `overflow`=0, `fifo_level`=0.
  - State goes to IDLE, FIFO pointers go to 0, `sclk_q`=0.
  - A frame that is in progress is abandoned. The line returns high on the edge where `rst` is sampled.
- **Throughput**
  - Lossless only if the sample rate is at most `clk`/(10·`CLKS_PER_BIT`).
  - Above that rate, `overflow` is the required indication. It is not an error in the block.

## Timing
- Push at edge N: the sample is written at edge N and `fifo_level` increments at edge N.
- If the block is IDLE with the FIFO empty before edge N:
  - The pop happens at edge N+1.
  - `uart_tx` goes low after edge N+1.
  - Push-to-start-bit latency is 2 cycles.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles.
  - Start bit: cycles 0..C-1.
  - Data bit k: cycles (k+1)·C .. (k+2)·C-1.
  - Stop bit: cycles 9C .. 10C-1.
- Back-to-back frames: the next start bit begins on the cycle right after the last stop cycle.
- `fifo_level` decrements on the pop edge.
- After `rst` deasserts, the first push can be accepted at the next edge. Because `sclk_q` resets to 0, an `sample_clk_in` that is already high right after reset is counted as an edge.

## Structure
- Package `cic_uart_pkg` holds:
  - the state typedef `tx_state_t` (IDLE, START, DATA, STOP);
  - `START_BIT`=1'b0, `STOP_BIT`=1'b1, `FRAME_BITS`=10, `BYTE_BITS`=8.
- One sub-module, `sync_fifo`, parameterized by width and depth.
  - Ports: push, pop, wdata, rdata, full, empty, level.
  - `rdata` is show-ahead: valid whenever not empty.
- The top level contains the edge detect, the TX FSM, the baud counter, the bit counter, the shift register, and the `overflow` flag.

## Test plan
- **Reset values:** hold `rst` 3 cycles, then release → `uart_tx`=1, `busy`=0, `overflow`=0, `fifo_level`=0. Line stays high with no push.
- **Single frame:** `CLKS_PER_BIT`=4, `sample_in`=7'h55, one rising edge of `sample_clk_in` → start bit after 2 cycles, then bits 1,0,1,0,1,0,1,0, then stop, 40 cycles total, then `busy`=0.
- **Back-to-back:** three edges with values 0x01, 0x7F, 0x40 → three 40-cycle frames with no gap. `fifo_level` sequence is 1,2,... and ends at 0.
- **Overflow:** `FIFO_DEPTH`=4, 6 edges while the first frame is in progress → `overflow`=1. Only the first 5 samples are sent: 1 in the shift register plus 4 queued. The flag stays set.
- **Full with simultaneous pop:** FIFO full, push on the exact last STOP cycle → no drop and `overflow` stays 0.
- **Mid-frame reset:** assert `rst` during DATA bit 3 → `uart_tx`=1 on the next edge, FIFO empty, and no residual frame after release.
